// File: rtl/instr_encode_loader.sv
// -----------------------------------------------------------------------------
// instr_encode_loader
//
// Packs instruction field bundles into the 19-bit word format unpacked by the
// ID stage and writes them sequentially into instruction memory starting at a
// programmable base address. Keeps word / branch counts and sticky error flags
// so software can cross-check what was loaded against ID branch prediction.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, base_addr    open a load session (honoured in IDLE/DONE), first addr
//   in_valid/in_ready   field bundle handshake; in_last closes the session
//   in_fmt              0 = R-format, 1 = I-format
//   in_opcode, in_rd, in_rs1, in_rs2, in_imm   instruction fields
//   imem_we/addr/wdata  registered instruction-memory write port
//   busy, done          LOAD / DONE state indicators
//   word_count          words written this session
//   branch_count        branch-opcode words written this session
//   err_imm             sticky: I-format imm[14] disagreed with opcode[0]
//   err_ovf             sticky: a bundle arrived after DEPTH words were written
// -----------------------------------------------------------------------------
module instr_encode_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              in_fmt,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [14:0]       in_imm,

    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [18:0]       imem_wdata,

    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [ADDR_W:0]   branch_count,
    output logic              err_imm,
    output logic              err_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [18:0]        r_wdata;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_word_count;
    logic [ADDR_W:0]    r_branch_count;
    logic               r_err_imm;
    logic               r_err_ovf;

    logic               w_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_conflict;
    logic               w_full;
    logic               w_write;
    logic               w_enter_load;
    logic               w_is_branch;
    logic [18:0]        w_pack;

    // ------------------------------------------------------------------
    // Field packing
    // ID reads the I-format immediate as bits [14:0], so imm[14] overlaps
    // opcode[0]; a bundle whose imm[14] disagrees cannot be encoded.
    // ------------------------------------------------------------------
    always_comb begin
        if (in_fmt) begin
            w_pack = {in_opcode, in_imm[13:0]};
        end else begin
            w_pack = {in_opcode, in_rd, in_rs1, in_rs2, 5'b00000};
        end
    end

    assign w_conflict  = in_fmt && (in_imm[14] != in_opcode[0]);
    assign w_is_branch = (in_opcode == 5'b01010) ||
                         (in_opcode == 5'b01011) ||
                         (in_opcode == 5'b01100);

    assign w_accept     = in_valid && w_ready;
    assign w_full       = (r_word_count == LP_DEPTH);
    // Overflowing or conflicting bundles are consumed without a write.
    assign w_write      = w_accept && !w_full && !w_conflict;
    assign w_enter_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                // start is deliberately ignored while loading
                if (w_accept && (in_last || w_full)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write register, pointer, counters and sticky status.
    // Session setup and writes are mutually exclusive (writes only happen
    // in LOAD, setup only from IDLE/DONE), so their updates never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_ptr          <= '0;
            r_word_count   <= '0;
            r_branch_count <= '0;
            r_err_imm      <= 1'b0;
            r_err_ovf      <= 1'b0;
        end else begin
            // one-cycle strobe per accepted, writable bundle
            r_we <= w_write;

            if (w_enter_load) begin
                r_ptr          <= base_addr;
                r_word_count   <= '0;
                r_branch_count <= '0;
                r_err_imm      <= 1'b0;
                r_err_ovf      <= 1'b0;
            end

            if (w_write) begin
                r_addr       <= r_ptr;
                r_wdata      <= w_pack;
                r_ptr        <= r_ptr + ADDR_W'(1);   // wraps at 2^ADDR_W
                r_word_count <= r_word_count + (ADDR_W+1)'(1);
                if (w_is_branch) begin
                    r_branch_count <= r_branch_count + (ADDR_W+1)'(1);
                end
            end

            if (w_accept && w_conflict) begin
                r_err_imm <= 1'b1;
            end
            if (w_accept && w_full) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign in_ready     = w_ready;
    assign busy         = w_busy;
    assign done         = w_done;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign word_count   = r_word_count;
    assign branch_count = r_branch_count;
    assign err_imm      = r_err_imm;
    assign err_ovf      = r_err_ovf;

endmodule

// File: tb/tb_instr_encode_loader.sv
module tb_instr_encode_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic          in_fmt;
    logic [4:0]    in_opcode;
    logic [2:0]    in_rd, in_rs1, in_rs2;
    logic [14:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [18:0]   imem_wdata;
    logic          busy, done;
    logic [AW:0]   word_count, branch_count;
    logic          err_imm, err_ovf;

    instr_encode_loader #(.ADDR_W(AW), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .word_count(word_count),
        .branch_count(branch_count), .err_imm(err_imm), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [18:0]   data;
    } wr_t;

    wr_t sb_q[$];
    wr_t mon_e;

    function automatic logic [18:0] pack_r(input logic [4:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 5'b00000};
    endfunction

    // Scoreboard: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_compare got addr=%h data=%h want addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic expect_wr(input logic [AW-1:0] a, input logic [18:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents a bundle and returns #1 after the edge that accepted it.
    task automatic push(input logic fmt, input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [14:0] imm, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        while (in_ready !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 16) begin
            checks++; errors++;
            $display("FAIL push_ready_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_last = 1'b0; in_fmt = 1'b0; in_opcode = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({imem_we, busy, done, err_imm, err_ovf, in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got we/busy/done/ei/eo/rdy=%b want 000000",
                     {imem_we, busy, done, err_imm, err_ovf, in_ready});
        end
        checks++;
        if (word_count !== '0 || branch_count !== '0) begin
            errors++;
            $display("FAIL reset_counts got wc=%0d bc=%0d want 0 0", word_count, branch_count);
        end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_port got addr=%h data=%h want 0 0", imem_addr, imem_wdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_r_format();
        do_start(8'h10);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got busy=%b rdy=%b want 1 1", busy, in_ready);
        end
        expect_wr(8'h10, 19'b00011_101_010_111_00000);
        push(1'b0, 5'b00011, 3'd5, 3'd2, 3'd7, 15'h0, 1'b1);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h10) begin
            errors++;
            $display("FAIL r_latency got we=%b addr=%h want 1 10", imem_we, imem_addr);
        end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL r_done got done=%b rdy=%b wc=%0d want 1 0 1", done, in_ready, word_count);
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0) begin
            errors++;
            $display("FAIL r_single_strobe got we=%b want 0", imem_we);
        end
    endtask

    task automatic test_i_format();
        do_start(8'h20);
        expect_wr(8'h20, {5'b01011, 14'h1ABC});
        push(1'b1, 5'b01011, 3'd0, 3'd0, 3'd0, 15'h5ABC, 1'b1);
        checks++;
        if (branch_count !== 9'd1 || word_count !== 9'd1 || err_imm !== 1'b0) begin
            errors++;
            $display("FAIL i_status got bc=%0d wc=%0d ei=%b want 1 1 0", branch_count, word_count, err_imm);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_imm_conflict();
        do_start(8'h30);
        push(1'b1, 5'b00010, 3'd0, 3'd0, 3'd0, 15'h4001, 1'b0);
        checks++;
        if (imem_we !== 1'b0 || err_imm !== 1'b1 || word_count !== 9'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL conflict_drop got we=%b ei=%b wc=%0d busy=%b want 0 1 0 1",
                     imem_we, err_imm, word_count, busy);
        end
        expect_wr(8'h30, pack_r(5'b00001, 3'd1, 3'd1, 3'd1));
        push(1'b0, 5'b00001, 3'd1, 3'd1, 3'd1, 15'h0, 1'b1);
        checks++;
        if (imem_addr !== 8'h30 || word_count !== 9'd1 || err_imm !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL conflict_after got addr=%h wc=%0d ei=%b done=%b want 30 1 1 1",
                     imem_addr, word_count, err_imm, done);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [4:0]    ops [4];
        logic [AW-1:0] a;
        ops = '{5'b01010, 5'b00001, 5'b01100, 5'b00111};
        do_start(8'hFE);
        checks++;
        if (err_imm !== 1'b0 || word_count !== 9'd0) begin
            errors++;
            $display("FAIL b2b_clear got ei=%b wc=%0d want 0 0", err_imm, word_count);
        end
        for (int i = 0; i < 4; i++) begin
            a = AW'(8'hFE + i);
            expect_wr(a, pack_r(ops[i], 3'(i), 3'(i + 1), 3'(i + 2)));
            push(1'b0, ops[i], 3'(i), 3'(i + 1), 3'(i + 2), 15'h0, (i == 3));
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== a) begin
                errors++;
                $display("FAIL b2b_cycle%0d got we=%b addr=%h want 1 %h", i, imem_we, imem_addr, a);
            end
        end
        checks++;
        if (branch_count !== 9'd2 || word_count !== 9'd4 || done !== 1'b1 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_status got bc=%0d wc=%0d done=%b eo=%b want 2 4 1 0",
                     branch_count, word_count, done, err_ovf);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        do_start(8'h40);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_wr(AW'(8'h40 + i), pack_r(5'b00001, 3'(i), 3'd0, 3'd0));
            push(1'b0, 5'b00001, 3'(i), 3'd0, 3'd0, 15'h0, (i == 4));
            if (i == 3) begin
                checks++;
                if (err_ovf !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_early got eo=%b busy=%b want 0 1", err_ovf, busy);
                end
            end
        end
        checks++;
        if (imem_we !== 1'b0 || err_ovf !== 1'b1 || done !== 1'b1 || word_count !== 9'd4) begin
            errors++;
            $display("FAIL ovf_final got we=%b eo=%b done=%b wc=%0d want 0 1 1 4",
                     imem_we, err_ovf, done, word_count);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        do_start(8'h50);
        expect_wr(8'h50, pack_r(5'b00100, 3'd1, 3'd2, 3'd3));
        push(1'b0, 5'b00100, 3'd1, 3'd2, 3'd3, 15'h0, 1'b0);
        idle();
        do_start(8'h70);   // ignored while loading
        checks++;
        if (busy !== 1'b1 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL start_in_load got busy=%b wc=%0d want 1 1", busy, word_count);
        end
        expect_wr(8'h51, pack_r(5'b00101, 3'd4, 3'd5, 3'd6));
        push(1'b0, 5'b00101, 3'd4, 3'd5, 3'd6, 15'h0, 1'b0);
        // third bundle is presented together with reset: it must be dropped
        in_opcode = 5'b00110;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({imem_we, busy, done, err_imm, err_ovf, in_ready} !== 6'b0 ||
            word_count !== '0 || branch_count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
            errors++;
            $display("FAIL mid_reset got we/busy/done/ei/eo/rdy=%b wc=%0d bc=%0d addr=%h data=%h want all 0",
                     {imem_we, busy, done, err_imm, err_ovf, in_ready},
                     word_count, branch_count, imem_addr, imem_wdata);
        end
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(8'h60);
        expect_wr(8'h60, pack_r(5'b00011, 3'd7, 3'd7, 3'd7));
        push(1'b0, 5'b00011, 3'd7, 3'd7, 3'd7, 15'h0, 1'b1);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h60 || word_count !== 9'd1) begin
            errors++;
            $display("FAIL reload got we=%b addr=%h wc=%0d want 1 60 1", imem_we, imem_addr, word_count);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_r_format();
        test_i_format();
        test_imm_conflict();
        test_back_to_back();
        test_overflow();
        test_reset_mid_load();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
